// File: rtl/odd_result_pipe_pkg.sv
// Shared definitions for the odd-pipe result pipeline.
// Holds the execution-unit code, the default per-unit result latencies and
// the per-stage control record. Address and data are parameter-width, so
// each stage carries them next to the record rather than inside it.
package odd_result_pipe_pkg;

  typedef enum logic [1:0] {
    UNIT_PERM = 2'd0,
    UNIT_LS   = 2'd1,
    UNIT_BR   = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  localparam int unsigned NUM_UNITS    = 3;
  localparam int unsigned DEF_LAT_PERM = 3;
  localparam int unsigned DEF_LAT_LS   = 5;
  localparam int unsigned DEF_LAT_BR   = 1;

  typedef struct packed {
    logic  valid;
    unit_e unit;
    logic  rw;
    logic  ready;
  } stage_entry_t;

endpackage

// File: rtl/odd_result_pipe_result_stage.sv
// result_stage: one register stage of the odd-pipe result pipeline.
// Loads the entry from the previous stage (or the issue port for STAGE 1)
// every cycle. If the incoming entry sits at its unit's result latency and
// the unit strobes done, the stage captures that unit's data and marks the
// entry ready. Flush kills entries arriving from stages 0..FLUSH_STAGES
// (stage 0 being the same-cycle issue).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   prev_entry/addr/data  contents of the preceding stage
//   unit_done, unit_data  per-unit result strobes and data
//   flush                 mispredict kill
//   entry, addr, data     this stage's registered contents
module result_stage
  import odd_result_pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned STAGE        = 1,
  parameter int unsigned LAT_PERM     = DEF_LAT_PERM,
  parameter int unsigned LAT_LS       = DEF_LAT_LS,
  parameter int unsigned LAT_BR       = DEF_LAT_BR,
  parameter int unsigned FLUSH_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  stage_entry_t          prev_entry,
  input  logic [ADDR_W-1:0]     prev_addr,
  input  logic [DATA_W-1:0]     prev_data,
  input  logic [2:0]            unit_done,
  input  logic [3*DATA_W-1:0]   unit_data,
  input  logic                  flush,
  output stage_entry_t          entry,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     data
);

  // Stage index the incoming entry currently occupies.
  localparam int unsigned SRC       = STAGE - 1;
  localparam bit          KILL_ZONE = (SRC <= FLUSH_STAGES);

  logic              hit;
  logic              done;
  logic              capture;
  logic              kill;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    hit      = 1'b0;
    done     = 1'b0;
    cap_data = '0;
    case (prev_entry.unit)
      UNIT_PERM: begin
        hit      = (SRC == LAT_PERM);
        done     = unit_done[0];
        cap_data = unit_data[0 +: DATA_W];
      end
      UNIT_LS: begin
        hit      = (SRC == LAT_LS);
        done     = unit_done[1];
        cap_data = unit_data[DATA_W +: DATA_W];
      end
      UNIT_BR: begin
        hit      = (SRC == LAT_BR);
        done     = unit_done[2];
        cap_data = unit_data[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
    capture = prev_entry.valid && hit && done;
    kill    = flush && KILL_ZONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
      addr  <= '0;
      data  <= '0;
    end else begin
      entry.valid <= prev_entry.valid && !kill;
      entry.unit  <= prev_entry.unit;
      entry.rw    <= prev_entry.rw;
      entry.ready <= prev_entry.ready || capture;
      addr        <= prev_addr;
      data        <= capture ? cap_data : prev_data;
    end
  end

endmodule

// File: rtl/odd_result_pipe.sv
// odd_result_pipe: fixed-length result pipeline for the odd execution pipe.
// Issued instructions travel DEPTH stages to writeback; each unit's result is
// merged in at that unit's latency stage. Every stage is exposed for operand
// forwarding. Protocol violations (missing or stray unit_done) set a sticky err.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   iss_valid/unit/rt_addr/reg_write   issue port
//   unit_done, unit_data               per-unit result strobe/data (unit u in slice u)
//   flush                              kills the youngest FLUSH_STAGES stages and the issue
//   fwd_valid/addr/data                per-stage forwarding view (stage k in slice k-1)
//   rt_wb, rt_addr_wb, reg_write_wb    writeback port (stage DEPTH)
//   err                                sticky protocol-error flag
module odd_result_pipe
  import odd_result_pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned DEPTH        = 7,
  parameter int unsigned LAT_PERM     = DEF_LAT_PERM,
  parameter int unsigned LAT_LS       = DEF_LAT_LS,
  parameter int unsigned LAT_BR       = DEF_LAT_BR,
  parameter int unsigned FLUSH_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iss_valid,
  input  logic [1:0]                iss_unit,
  input  logic [ADDR_W-1:0]         iss_rt_addr,
  input  logic                      iss_reg_write,
  input  logic [2:0]                unit_done,
  input  logic [3*DATA_W-1:0]       unit_data,
  input  logic                      flush,
  output logic [DEPTH-1:0]          fwd_valid,
  output logic [DEPTH*ADDR_W-1:0]   fwd_addr,
  output logic [DEPTH*DATA_W-1:0]   fwd_data,
  output logic [DATA_W-1:0]         rt_wb,
  output logic [ADDR_W-1:0]         rt_addr_wb,
  output logic                      reg_write_wb,
  output logic                      err
);

  if (LAT_PERM == 0 || LAT_PERM > DEPTH - 1 ||
      LAT_LS   == 0 || LAT_LS   > DEPTH - 1 ||
      LAT_BR   == 0 || LAT_BR   > DEPTH - 1 ||
      FLUSH_STAGES > DEPTH) begin : g_param_check
    $error("odd_result_pipe: latencies must lie in 1..DEPTH-1 and FLUSH_STAGES <= DEPTH");
  end

  stage_entry_t      issue_ent;
  stage_entry_t      src_ent  [DEPTH];
  stage_entry_t      ent      [DEPTH];
  logic [ADDR_W-1:0] src_addr [DEPTH];
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [NUM_UNITS-1:0] err_hit;

  // Undefined unit code enters as a nop: already ready, never writes.
  always_comb begin
    issue_ent.valid = iss_valid;
    issue_ent.unit  = unit_e'(iss_unit);
    issue_ent.rw    = iss_reg_write && (unit_e'(iss_unit) != UNIT_NONE);
    issue_ent.ready = (unit_e'(iss_unit) == UNIT_NONE);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_ent[k]  = issue_ent;
      assign src_addr[k] = iss_rt_addr;
      assign src_data[k] = '0;
    end else begin : g_body
      assign src_ent[k]  = ent[k-1];
      assign src_addr[k] = addr_q[k-1];
      assign src_data[k] = data_q[k-1];
    end

    result_stage #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .STAGE       (k + 1),
      .LAT_PERM    (LAT_PERM),
      .LAT_LS      (LAT_LS),
      .LAT_BR      (LAT_BR),
      .FLUSH_STAGES(FLUSH_STAGES)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .prev_entry(src_ent[k]),
      .prev_addr (src_addr[k]),
      .prev_data (src_data[k]),
      .unit_done (unit_done),
      .unit_data (unit_data),
      .flush     (flush),
      .entry     (ent[k]),
      .addr      (addr_q[k]),
      .data      (data_q[k])
    );

    assign fwd_valid[k]                   = ent[k].valid && ent[k].rw && ent[k].ready;
    assign fwd_addr[k*ADDR_W +: ADDR_W]   = addr_q[k];
    assign fwd_data[k*DATA_W +: DATA_W]   = ent[k].ready ? data_q[k] : '0;
  end

  assign reg_write_wb = fwd_valid[DEPTH-1];
  assign rt_addr_wb   = addr_q[DEPTH-1];
  assign rt_wb        = fwd_data[(DEPTH-1)*DATA_W +: DATA_W];

  // Per unit: a strobe with no entry of that unit at its latency stage is
  // stray; a live entry there without a strobe missed its result. Entries
  // being killed by flush neither need nor accept a strobe.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_err
    localparam int unsigned LAT      = (u == 0) ? LAT_PERM : (u == 1) ? LAT_LS : LAT_BR;
    localparam bit          KILLABLE = (LAT <= FLUSH_STAGES);
    logic present;
    assign present    = ent[LAT-1].valid && (2'(ent[LAT-1].unit) == 2'(u));
    assign err_hit[u] = (unit_done[u] && !present) ||
                        (present && !(flush && KILLABLE) && !unit_done[u]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (|err_hit) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_odd_result_pipe.sv
// Directed bench for odd_result_pipe with default parameters.
// Inputs change and outputs are sampled on the falling edge; within each
// test, c counts rising edges since the test's first falling edge.
module tb_odd_result_pipe;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int D  = 7;

  localparam logic [DW-1:0] PAT_A = {16{8'hAA}};
  localparam logic [DW-1:0] PAT_1 = {16{8'h11}};
  localparam logic [DW-1:0] PAT_2 = {16{8'h22}};
  localparam logic [DW-1:0] PAT_3 = {16{8'h33}};
  localparam logic [DW-1:0] PAT_5 = {16{8'h55}};
  localparam logic [DW-1:0] PAT_C = {16{8'hC3}};

  logic              clk;
  logic              reset;
  logic              iss_valid;
  logic [1:0]        iss_unit;
  logic [AW-1:0]     iss_rt_addr;
  logic              iss_reg_write;
  logic [2:0]        unit_done;
  logic [3*DW-1:0]   unit_data;
  logic              flush;
  logic [D-1:0]      fwd_valid;
  logic [D*AW-1:0]   fwd_addr;
  logic [D*DW-1:0]   fwd_data;
  logic [DW-1:0]     rt_wb;
  logic [AW-1:0]     rt_addr_wb;
  logic              reg_write_wb;
  logic              err;

  int tests_run = 0;
  int tests_failed = 0;

  odd_result_pipe #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_unit     (iss_unit),
    .iss_rt_addr  (iss_rt_addr),
    .iss_reg_write(iss_reg_write),
    .unit_done    (unit_done),
    .unit_data    (unit_data),
    .flush        (flush),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .rt_wb        (rt_wb),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    iss_valid     = 1'b0;
    iss_unit      = 2'd0;
    iss_rt_addr   = '0;
    iss_reg_write = 1'b0;
    unit_done     = 3'b000;
    unit_data     = '0;
    flush         = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] unit, input logic [AW-1:0] a, input logic rw);
    iss_valid     = 1'b1;
    iss_unit      = unit;
    iss_rt_addr   = a;
    iss_reg_write = rw;
  endtask

  // Leaves the bench on a falling edge with the pipe empty and err clear.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_issue(2'd0, 7'd9, 1'b1);
    unit_done = 3'b111;
    unit_data = '1;
    repeat (2) @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL reset_reg_write_wb c=%0d got %b exp 0", c, reg_write_wb); end
      tests_run++;
      if (rt_wb !== '0) begin tests_failed++; $display("FAIL reset_rt_wb c=%0d got %h exp 0", c, rt_wb); end
      tests_run++;
      if (rt_addr_wb !== '0) begin tests_failed++; $display("FAIL reset_rt_addr_wb c=%0d got %h exp 0", c, rt_addr_wb); end
      tests_run++;
      if (fwd_valid !== '0) begin tests_failed++; $display("FAIL reset_fwd_valid c=%0d got %b exp 0", c, fwd_valid); end
      tests_run++;
      if (fwd_addr !== '0) begin tests_failed++; $display("FAIL reset_fwd_addr c=%0d got %h exp 0", c, fwd_addr); end
      tests_run++;
      if (fwd_data !== '0) begin tests_failed++; $display("FAIL reset_fwd_data c=%0d got %h exp 0", c, fwd_data); end
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err c=%0d got %b exp 0", c, err); end
      @(negedge clk);
    end
  endtask

  task automatic test_perm();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c == 3) begin
        tests_run++;
        if (fwd_valid[2] !== 1'b0) begin tests_failed++; $display("FAIL perm_not_ready_s3 got %b exp 0", fwd_valid[2]); end
      end
      if (c == 4) begin
        tests_run++;
        if (fwd_valid[3] !== 1'b1) begin tests_failed++; $display("FAIL perm_fwd_valid_s4 got %b exp 1", fwd_valid[3]); end
        tests_run++;
        if (fwd_addr[3*AW +: AW] !== 7'd5) begin tests_failed++; $display("FAIL perm_fwd_addr_s4 got %h exp 5", fwd_addr[3*AW +: AW]); end
        tests_run++;
        if (fwd_data[3*DW +: DW] !== PAT_A) begin tests_failed++; $display("FAIL perm_fwd_data_s4 got %h exp %h", fwd_data[3*DW +: DW], PAT_A); end
      end
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b1) begin tests_failed++; $display("FAIL perm_wb_we got %b exp 1", reg_write_wb); end
        tests_run++;
        if (rt_addr_wb !== 7'd5) begin tests_failed++; $display("FAIL perm_wb_addr got %h exp 5", rt_addr_wb); end
        tests_run++;
        if (rt_wb !== PAT_A) begin tests_failed++; $display("FAIL perm_wb_data got %h exp %h", rt_wb, PAT_A); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL perm_err got %b exp 0", err); end
      end
      if (c == 8) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL perm_wb_once got %b exp 0", reg_write_wb); end
      end
      clear_inputs();
      if (c == 0) set_issue(2'd0, 7'd5, 1'b1);
      if (c == 3) begin unit_done = 3'b001; unit_data[0 +: DW] = PAT_A; end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b1 || rt_addr_wb !== 7'd10 || rt_wb !== PAT_1) begin
          tests_failed++; $display("FAIL b2b_wb_ls got we=%b addr=%h data=%h exp 1/0a/%h", reg_write_wb, rt_addr_wb, rt_wb, PAT_1);
        end
      end
      if (c == 8) begin
        tests_run++;
        if (reg_write_wb !== 1'b1 || rt_addr_wb !== 7'd11 || rt_wb !== PAT_2) begin
          tests_failed++; $display("FAIL b2b_wb_br got we=%b addr=%h data=%h exp 1/0b/%h", reg_write_wb, rt_addr_wb, rt_wb, PAT_2);
        end
      end
      if (c == 9) begin
        tests_run++;
        if (reg_write_wb !== 1'b1 || rt_addr_wb !== 7'd12 || rt_wb !== PAT_3) begin
          tests_failed++; $display("FAIL b2b_wb_perm got we=%b addr=%h data=%h exp 1/0c/%h", reg_write_wb, rt_addr_wb, rt_wb, PAT_3);
        end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL b2b_err got %b exp 0", err); end
      end
      if (c == 10) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got %b exp 0", reg_write_wb); end
      end
      clear_inputs();
      if (c == 0) set_issue(2'd1, 7'd10, 1'b1);
      if (c == 1) set_issue(2'd2, 7'd11, 1'b1);
      if (c == 2) begin
        set_issue(2'd0, 7'd12, 1'b1);
        unit_done = 3'b100;
        unit_data[2*DW +: DW] = PAT_2;
      end
      // LS reaches stage 5 and Perm stage 3 together: both capture at once.
      if (c == 5) begin
        unit_done = 3'b011;
        unit_data[0 +: DW]  = PAT_3;
        unit_data[DW +: DW] = PAT_1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_missing_done();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c == 3) begin
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL miss_err_early got %b exp 0", err); end
      end
      if (c == 4) begin
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL miss_err_set got %b exp 1", err); end
      end
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL miss_wb_we got %b exp 0", reg_write_wb); end
        tests_run++;
        if (rt_addr_wb !== 7'd7) begin tests_failed++; $display("FAIL miss_wb_addr got %h exp 7", rt_addr_wb); end
        tests_run++;
        if (rt_wb !== '0) begin tests_failed++; $display("FAIL miss_wb_data got %h exp 0", rt_wb); end
      end
      if (c == 8) begin
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL miss_err_sticky got %b exp 1", err); end
      end
      clear_inputs();
      if (c == 0) set_issue(2'd0, 7'd7, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c == 5) begin
        tests_run++;
        if (fwd_valid !== 7'b0000000) begin tests_failed++; $display("FAIL flush_fwd_valid got %b exp 0000000", fwd_valid); end
      end
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b1 || rt_addr_wb !== 7'd20 || rt_wb !== PAT_5) begin
          tests_failed++; $display("FAIL flush_ls_wb got we=%b addr=%h data=%h exp 1/14/%h", reg_write_wb, rt_addr_wb, rt_wb, PAT_5);
        end
      end
      if (c == 9 || c == 10) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL flush_br_wb c=%0d got %b exp 0", c, reg_write_wb); end
      end
      if (c == 10) begin
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL flush_err got %b exp 0", err); end
      end
      clear_inputs();
      if (c == 0) set_issue(2'd1, 7'd20, 1'b1);
      if (c == 2) set_issue(2'd2, 7'd21, 1'b1);
      if (c == 3) begin
        set_issue(2'd2, 7'd22, 1'b1);
        unit_done = 3'b100;
        unit_data[2*DW +: DW] = PAT_2;
      end
      // Br entries in stages 1-2, LS in stage 4; strobe to the dying Br is ignored.
      if (c == 4) begin
        flush = 1'b1;
        set_issue(2'd2, 7'd23, 1'b1);
        unit_done = 3'b100;
        unit_data[2*DW +: DW] = PAT_3;
      end
      if (c == 5) begin
        unit_done = 3'b010;
        unit_data[DW +: DW] = PAT_5;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stray_and_reset();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c == 1) begin
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL stray_err got %b exp 1", err); end
      end
      if (c == 4) begin
        tests_run++;
        if (fwd_valid[3] !== 1'b1) begin tests_failed++; $display("FAIL inflight_fwd_s4 got %b exp 1", fwd_valid[3]); end
      end
      if (c == 5) begin
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err_clear got %b exp 0", err); end
        tests_run++;
        if (fwd_valid !== '0) begin tests_failed++; $display("FAIL rst_fwd_valid got %b exp 0", fwd_valid); end
      end
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL rst_no_wb got %b exp 0", reg_write_wb); end
      end
      clear_inputs();
      if (c == 0) begin
        set_issue(2'd0, 7'd3, 1'b1);
        unit_done = 3'b010;
      end
      if (c == 3) begin unit_done = 3'b001; unit_data[0 +: DW] = PAT_C; end
      if (c == 4) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_nop();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) begin
        tests_run++;
        if (fwd_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL nop_fwd_s1 got %b exp 0", fwd_valid[0]); end
      end
      if (c == 7) begin
        tests_run++;
        if (reg_write_wb !== 1'b0) begin tests_failed++; $display("FAIL nop_wb got %b exp 0", reg_write_wb); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL nop_err got %b exp 0", err); end
      end
      clear_inputs();
      if (c == 0) set_issue(2'd3, 7'd9, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_perm();
    test_back_to_back();
    test_missing_done();
    test_flush();
    test_stray_and_reset();
    test_nop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
